bus_master_if: RTL and testbench
================================

Name: bus_master_if

Overview:
- Initiator-side bus interface unit: converts a simple single-transfer request from a local core (CPU, DMA) into the shared-bus master protocol.
- Protocol: req/grnt arbitration, then as/rw/addr/wr_data, then wait for rdy and capture rd_data.
- One instance per master port m0..m3; bus-side outputs connect directly to that port's bus_mN_* signals.
- Provides stall, completion and error status to the core.

Parameters:
- ADDR_W, 30, bus address width; equals the `BUS_SLAVE_ADDR width.
- DATA_W, 32, data width; equals the `WORD_DATA width.
- TIMEOUT, 256, maximum cycles in ACCESS+WAIT before abort; 0 disables the timeout.
- TO_W, 9, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rest  in  1  reset, synchronous, active-low
- cpu_req  in  1  transfer request; sampled only in IDLE
- cpu_addr  in  ADDR_W  target address
- cpu_rw  in  1  1=read, 0=write
- cpu_wr_data  in  DATA_W  write data
- cpu_rd_data  out  DATA_W  read data, valid with cpu_done
- cpu_busy  out  1  1 whenever state != IDLE
- cpu_done  out  1  one-cycle pulse on successful completion
- cpu_err  out  1  one-cycle pulse on timeout or grant loss
- bus_req  out  1  to bus_mN_req
- bus_grnt  in  1  from bus_mN_grnt
- bus_addr  out  ADDR_W  to bus_mN_addr
- bus_as  out  1  address strobe, active-high
- bus_rw  out  1  1=read, 0=write
- bus_wr_data  out  DATA_W  to bus_mN_wr_data
- bus_rdy  in  1  selected slave ready
- bus_rd_data  in  DATA_W  selected slave read data

Behaviour:
- One clock (clk). Reset (rest) is synchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; bus_req=0, bus_as=0, bus_rw=0, bus_addr=0, bus_wr_data=0, cpu_rd_data=0, cpu_busy=0, cpu_done=0, cpu_err=0; timeout counter=0.
- Reset while a transfer is in flight aborts it immediately: bus_req drops at that edge and no done/err pulse is issued.

State machine (IDLE, REQ, ACCESS, WAIT):
- IDLE:
  - cpu_req=1 latches addr/rw/wr_data into internal registers.
  - Next state REQ; bus_req<=1.
  - cpu_addr, cpu_rw and cpu_wr_data are don't-care after the accept edge.
- REQ:
  - Hold bus_req=1; wait indefinitely for grnt (no timeout here).
  - On grnt=1: next state ACCESS; drive bus_as<=1 and bus_addr/bus_rw/bus_wr_data from the latched values.
- ACCESS (exactly one cycle, as=1):
  - bus_as<=0 at the next edge.
  - rdy=1 at that edge: complete.
  - Otherwise: next state WAIT.
- WAIT:
  - bus_req, addr, rw and wr_data stay stable; as=0.
  - Sample rdy at each edge.
- Complete:
  - cpu_rd_data<=bus_rd_data on reads only; held unchanged on writes.
  - cpu_done<=1; bus_req<=0; bus_addr, bus_wr_data and bus_rw return to 0; next state IDLE.

Timing and arbitration rules:
- Bus-side addr/wr_data/rw are zero outside ACCESS/WAIT, so the OR-style mux is safe.
- Minimum latency: accept edge E, done visible after E+3 (immediate grant, zero-wait slave).
- Back-to-back: cpu_req held high through done is re-accepted at the edge after done. One idle cycle with bus_req=0 always separates transfers, giving the arbiter a re-arbitration point.

Timeout and errors:
- Counter clears on entry to ACCESS and increments each cycle in ACCESS/WAIT.
- If TIMEOUT≠0 and the count reaches TIMEOUT-1 with rdy=0: abort.
- Abort: cpu_err<=1, bus_req<=0, outputs zeroed, next state IDLE, cpu_rd_data unchanged.
- grnt=0 in ACCESS/WAIT is a protocol violation: same abort as timeout.
- rdy and the timeout hit on the same edge: rdy wins (done, not err).
- rdy=1 outside ACCESS/WAIT is ignored.

Decomposition:
- Shared constants go in global.v: ADDR_W/DATA_W derived from `BUS_SLAVE_ADDR/`WORD_DATA; `BUS_READ=1'b1, `BUS_WRITE=1'b0; state encodings `BMI_IDLE/REQ/ACCESS/WAIT (2-bit).
- No sub-module required; the timeout counter stays inline.

Test Plan:
- Read, immediate grant, zero-wait slave returning 32'hDEAD_BEEF at addr 30'h0000_0100 -> as high exactly 1 cycle; cpu_done at accept+3; cpu_rd_data=32'hDEAD_BEEF; bus_req low the cycle after.
- Write 32'h1234_5678 to 30'h2000_0004, slave with 2 wait states -> as one cycle, addr/wr_data stable through WAIT; done at accept+5; cpu_rd_data unchanged.
- Grant withheld 7 cycles (another master holding bus) -> bus_req held, as=0, no timeout; transfer completes normally after grant.
- TIMEOUT=16, slave never ready -> cpu_err pulse exactly 16 cycles after ACCESS entry; bus_req drops; next request proceeds normally. Repeat with rdy on the final cycle -> done, no err.
- cpu_req held high for 3 reads -> three done pulses, each separated by a bus_req=0 cycle; grant released between transfers.
- rest=0 asserted mid-WAIT -> next edge: all outputs at reset values, no done/err; later request succeeds.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// rtl/bus_master_if_pkg.sv - shared constants and state encoding for the bus master interface
package bus_master_if_pkg;

   localparam int BUS_SLAVE_ADDR_W = 30;
   localparam int WORD_DATA_W      = 32;

   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   typedef enum logic [1:0] {
      BMI_IDLE   = 2'd0,
      BMI_REQ    = 2'd1,
      BMI_ACCESS = 2'd2,
      BMI_WAIT   = 2'd3
   } bmi_state_e;

endpackage

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - initiator-side unit turning single core requests into shared-bus transfers
module bus_master_if
   import bus_master_if_pkg::*;
#(
   parameter int ADDR_W  = BUS_SLAVE_ADDR_W,
   parameter int DATA_W  = WORD_DATA_W,
   parameter int TIMEOUT = 256,
   parameter int TO_W    = 9
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rw,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              cpu_busy,
   output logic              cpu_done,
   output logic              cpu_err,
   output logic              bus_req,
   input  logic              bus_grnt,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic              bus_rdy,
   input  logic [DATA_W-1:0] bus_rd_data
);

   bmi_state_e        state, state_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic              lat_rw, lat_rw_nxt;
   logic [DATA_W-1:0] lat_wr_data, lat_wr_data_nxt;
   logic [TO_W-1:0]   cnt, cnt_nxt;

   logic [DATA_W-1:0] cpu_rd_data_nxt;
   logic              cpu_busy_nxt, cpu_done_nxt, cpu_err_nxt;
   logic              bus_req_nxt, bus_as_nxt, bus_rw_nxt;
   logic [ADDR_W-1:0] bus_addr_nxt;
   logic [DATA_W-1:0] bus_wr_data_nxt;
   logic              to_hit;

   assign to_hit = (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt       = state;
      lat_addr_nxt    = lat_addr;
      lat_rw_nxt      = lat_rw;
      lat_wr_data_nxt = lat_wr_data;
      cnt_nxt         = cnt;
      cpu_rd_data_nxt = cpu_rd_data;
      cpu_done_nxt    = 1'b0;
      cpu_err_nxt     = 1'b0;
      bus_req_nxt     = bus_req;
      bus_as_nxt      = bus_as;
      bus_rw_nxt      = bus_rw;
      bus_addr_nxt    = bus_addr;
      bus_wr_data_nxt = bus_wr_data;

      case (state)
         BMI_IDLE: begin
            if (cpu_req) begin
               lat_addr_nxt    = cpu_addr;
               lat_rw_nxt      = cpu_rw;
               lat_wr_data_nxt = cpu_wr_data;
               bus_req_nxt     = 1'b1;
               state_nxt       = BMI_REQ;
            end
         end
         BMI_REQ: begin
            if (bus_grnt) begin
               bus_as_nxt      = 1'b1;
               bus_addr_nxt    = lat_addr;
               bus_rw_nxt      = lat_rw;
               bus_wr_data_nxt = lat_wr_data;
               cnt_nxt         = '0;
               state_nxt       = BMI_ACCESS;
            end
         end
         BMI_ACCESS, BMI_WAIT: begin
            bus_as_nxt = 1'b0;
            cnt_nxt    = cnt + TO_W'(1);
            // rdy is checked first so a ready on the timeout edge still completes
            if (bus_rdy || !bus_grnt || to_hit) begin
               if (bus_rdy) begin
                  cpu_done_nxt = 1'b1;
                  if (lat_rw == BUS_READ)
                     cpu_rd_data_nxt = bus_rd_data;
               end else begin
                  cpu_err_nxt = 1'b1;
               end
               bus_req_nxt     = 1'b0;
               bus_addr_nxt    = '0;
               bus_rw_nxt      = BUS_WRITE;
               bus_wr_data_nxt = '0;
               state_nxt       = BMI_IDLE;
            end else begin
               state_nxt = BMI_WAIT;
            end
         end
         default: state_nxt = BMI_IDLE;
      endcase

      cpu_busy_nxt = (state_nxt != BMI_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rest) begin
         state       <= BMI_IDLE;
         lat_addr    <= '0;
         lat_rw      <= 1'b0;
         lat_wr_data <= '0;
         cnt         <= '0;
         cpu_rd_data <= '0;
         cpu_busy    <= 1'b0;
         cpu_done    <= 1'b0;
         cpu_err     <= 1'b0;
         bus_req     <= 1'b0;
         bus_as      <= 1'b0;
         bus_rw      <= 1'b0;
         bus_addr    <= '0;
         bus_wr_data <= '0;
      end else begin
         state       <= state_nxt;
         lat_addr    <= lat_addr_nxt;
         lat_rw      <= lat_rw_nxt;
         lat_wr_data <= lat_wr_data_nxt;
         cnt         <= cnt_nxt;
         cpu_rd_data <= cpu_rd_data_nxt;
         cpu_busy    <= cpu_busy_nxt;
         cpu_done    <= cpu_done_nxt;
         cpu_err     <= cpu_err_nxt;
         bus_req     <= bus_req_nxt;
         bus_as      <= bus_as_nxt;
         bus_rw      <= bus_rw_nxt;
         bus_addr    <= bus_addr_nxt;
         bus_wr_data <= bus_wr_data_nxt;
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - self-checking bench for bus_master_if with a timeline-based reference model
module tb_bus_master_if;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rest;
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_rw;
   logic [DW-1:0] cpu_wr_data;
   logic [DW-1:0] cpu_rd_data;
   logic          cpu_busy, cpu_done, cpu_err;
   logic          bus_req, bus_grnt, bus_as, bus_rw, bus_rdy;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wr_data, bus_rd_data;

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_rd = '0;

   always #5 clk = ~clk;

   bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(9)) dut (
      .clk(clk), .rest(rest),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wr_data(cpu_wr_data),
      .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
      .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_addr(bus_addr), .bus_as(bus_as),
      .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph, input logic req, input logic as, input logic done,
                            input logic err, input logic busy, input logic [AW-1:0] a,
                            input logic rw, input logic [DW-1:0] wd);
      chk({ph, ".bus_req"}, 64'(bus_req), 64'(req));
      chk({ph, ".bus_as"}, 64'(bus_as), 64'(as));
      chk({ph, ".cpu_done"}, 64'(cpu_done), 64'(done));
      chk({ph, ".cpu_err"}, 64'(cpu_err), 64'(err));
      chk({ph, ".cpu_busy"}, 64'(cpu_busy), 64'(busy));
      chk({ph, ".bus_addr"}, 64'(bus_addr), 64'(a));
      chk({ph, ".bus_rw"}, 64'(bus_rw), 64'(rw));
      chk({ph, ".bus_wr_data"}, 64'(bus_wr_data), 64'(wd));
      chk({ph, ".cpu_rd_data"}, 64'(cpu_rd_data), 64'(exp_rd));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rest = 1'b1; cpu_req = 1'b0; bus_grnt = 1'b0;
         bus_rdy = 1'($urandom); bus_rd_data = $urandom;
         @(posedge clk); #1;
         check_all("idle", 0, 0, 0, 0, 0, '0, 0, '0);
      end
   endtask

   // Timeline model: grant seen g+2 edges after accept, rdy w edges after the strobe edge,
   // timeout TO edges after access entry, optional grant drop / reset edge.
   task automatic xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] rdata, input int g, input int w, input int drop,
                       input int rst_k, input bit hold);
      int  a_k, rdy_k, to_k, drop_k, end_k;
      bit  ok, by_rst;
      a_k    = 2 + g;
      rdy_k  = a_k + 1 + w;
      to_k   = a_k + TO;
      drop_k = (drop >= 0) ? a_k + 1 + drop : (1 << 30);
      end_k  = rdy_k;
      if (to_k < end_k) end_k = to_k;
      if (drop_k < end_k) end_k = drop_k;
      ok     = (rdy_k <= to_k) && (rdy_k <= drop_k);
      by_rst = (rst_k > 0) && (rst_k <= end_k);
      if (by_rst) end_k = rst_k;

      @(negedge clk);
      rest = 1'b1; cpu_req = 1'b1; cpu_addr = addr; cpu_rw = rw; cpu_wr_data = wdata;
      bus_grnt = 1'b0; bus_rdy = 1'($urandom); bus_rd_data = $urandom;
      @(posedge clk); #1;
      check_all("accept", 1, 0, 0, 0, 1, '0, 0, '0);

      for (int k = 1; k <= end_k; k++) begin
         @(negedge clk);
         cpu_req = hold; cpu_addr = AW'($urandom); cpu_rw = 1'($urandom); cpu_wr_data = $urandom;
         bus_grnt    = (k >= a_k) && (k < drop_k);
         bus_rdy     = (k == rdy_k) ? 1'b1 : ((k <= a_k) ? 1'($urandom) : 1'b0);
         bus_rd_data = (k == rdy_k) ? rdata : $urandom;
         if (by_rst && k == rst_k) rest = 1'b0;
         @(posedge clk); #1;
         if (k == end_k) begin
            if (by_rst) begin
               exp_rd = '0;
               check_all("reset", 0, 0, 0, 0, 0, '0, 0, '0);
            end else begin
               if (ok && rw) exp_rd = rdata;
               check_all(ok ? "done" : "abort", 0, 0, ok, !ok, 0, '0, 0, '0);
            end
         end else if (k >= a_k) begin
            check_all("bus", 1, (k == a_k), 0, 0, 1, addr, rw, wdata);
         end else begin
            check_all("req", 1, 0, 0, 0, 1, '0, 0, '0);
         end
      end
   endtask

   initial begin
      int g, w, drop;
      bit hold;
      rest = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_rw = 1'b0; cpu_wr_data = '0;
      bus_grnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all("rst", 0, 0, 0, 0, 0, '0, 0, '0);
      idle(2);

      xfer(1'b1, 30'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, 0, 0);
      idle(1);
      xfer(1'b0, 30'h2000_0004, 32'h1234_5678, $urandom, 0, 2, -1, 0, 0);
      idle(1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 7, 1, -1, 0, 0);
      idle(1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 40, -1, 0, 0);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 1, 0, -1, 0, 0);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 15, -1, 0, 0);
      idle(1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 0, -1, 0, 1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 1, 1, -1, 0, 1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 2, -1, 0, 0);
      idle(1);
      xfer(1'b0, AW'($urandom), $urandom, $urandom, 0, 5, 2, 0, 0);
      idle(1);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 10, -1, 5, 0);
      idle(2);
      xfer(1'b1, AW'($urandom), $urandom, $urandom, 0, 1, -1, 0, 0);
      idle(1);

      for (int i = 0; i < 24; i++) begin
         g    = int'($urandom_range(0, 3));
         w    = int'($urandom_range(0, 18));
         drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
         hold = (i != 23) && ($urandom_range(0, 2) == 0);
         xfer(1'($urandom), AW'($urandom), $urandom, $urandom, g, w, drop, 0, hold);
         if (!hold) idle(int'($urandom_range(0, 2)));
      end
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
